// File: rtl/ysyx_22040125_ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decoder
// channel, redirect input and delivered-instruction counter.
interface ysyx_22040125_ifu_fetch_if #(
   parameter int ADDR_W = 64
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic [63:0]       fetch_count;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_count,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_count,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ysyx_22040125_ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps one memory read in flight,
// buffers the returned word for the decoder and squashes stale fetches on redirect.
module ysyx_22040125_ifu_fetch #(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input logic                         clk,
   input logic                         rst,
   ysyx_22040125_ifu_fetch_if.master   bus
);
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DROP,
      ST_HOLD
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_nxt;
   logic [31:0]       inst_q, inst_nxt;
   logic [63:0]       cnt, cnt_nxt;
   logic [ADDR_W-1:0] redir_tgt;

   assign redir_tgt          = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
   assign bus.imem_req_valid = (state == ST_REQ);
   assign bus.imem_req_addr  = pc;
   assign bus.inst_valid     = (state == ST_HOLD);
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.fetch_count    = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pc        <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= '0;
         cnt       <= '0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         inst_q    <= inst_nxt;
         inst_pc_q <= inst_pc_nxt;
         cnt       <= cnt_nxt;
      end
   end

   // A redirect while a request is outstanding parks in DROP until its response drains.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      inst_nxt    = inst_q;
      inst_pc_nxt = inst_pc_q;
      cnt_nxt     = cnt;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_REQ;
            if (bus.redirect_valid) pc_nxt = redir_tgt;
         end
         ST_REQ: begin
            if (bus.imem_req_ready && bus.redirect_valid) begin
               pc_nxt    = redir_tgt;
               state_nxt = ST_DROP;
            end else if (bus.redirect_valid) begin
               pc_nxt = redir_tgt;
            end else if (bus.imem_req_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.imem_rsp_valid && bus.redirect_valid) begin
               pc_nxt    = redir_tgt;
               state_nxt = ST_REQ;
            end else if (bus.redirect_valid) begin
               pc_nxt    = redir_tgt;
               state_nxt = ST_DROP;
            end else if (bus.imem_rsp_valid) begin
               inst_nxt    = bus.imem_rsp_data;
               inst_pc_nxt = pc;
               state_nxt   = ST_HOLD;
            end
         end
         ST_DROP: begin
            if (bus.redirect_valid) pc_nxt = redir_tgt;
            if (bus.imem_rsp_valid) state_nxt = ST_REQ;
         end
         ST_HOLD: begin
            if (bus.inst_ready) cnt_nxt = cnt + 64'd1;
            if (bus.redirect_valid) begin
               pc_nxt    = redir_tgt;
               state_nxt = ST_REQ;
            end else if (bus.inst_ready) begin
               pc_nxt    = pc + ADDR_W'(4);
               state_nxt = ST_REQ;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ysyx_22040125_ifu_fetch.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of PC flow, outstanding fetches and deliveries.
module tb_ysyx_22040125_ifu_fetch;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   ysyx_22040125_ifu_fetch_if #(.ADDR_W(64)) bus ();

   ysyx_22040125_ifu_fetch #(.ADDR_W(64), .RESET_PC(RST_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state, valid between edges (sampled at negedge).
   logic [63:0] m_pc;
   logic [63:0] m_cnt;
   logic [63:0] m_addr;
   logic [31:0] m_inst;
   logic        m_idle, m_out, m_hold, m_clean;
   int          m_wait;
   int          mem_delay;
   bit          use_hash;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (!use_hash) return 32'h0000_0013;
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_cnt = '0; m_addr = '0; m_inst = '0;
      m_idle = 1'b1; m_out = 1'b0; m_hold = 1'b0; m_clean = 1'b0; m_wait = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
      check({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'd0);
      check({tag, "_req_addr"}, bus.imem_req_addr, RST_PC);
      check({tag, "_inst"}, 64'(bus.inst), 64'd0);
      check({tag, "_inst_pc"}, bus.inst_pc, 64'd0);
      check({tag, "_count"}, bus.fetch_count, 64'd0);
   endtask

   // Called at a negedge: check outputs, drive inputs, advance model, move to next negedge.
   task automatic step(input logic rdy, input logic irdy, input logic rv,
                       input logic [63:0] rpc, input logic junk);
      logic rsp_now, acc, take;
      check("req_valid", 64'(bus.imem_req_valid), 64'(!m_idle && !m_out && !m_hold));
      check("inst_valid", 64'(bus.inst_valid), 64'(m_hold));
      check("req_addr", bus.imem_req_addr, m_pc);
      check("fetch_count", bus.fetch_count, m_cnt);
      if (m_hold) begin
         check("inst_pc", bus.inst_pc, m_pc);
         check("inst", 64'(bus.inst), 64'(m_inst));
      end
      rsp_now = m_out && (m_wait == 0);
      bus.imem_req_ready = rdy;
      bus.inst_ready     = irdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.imem_rsp_valid = rsp_now || (!m_out && junk);
      bus.imem_rsp_data  = rsp_now ? mem_word(m_addr) : $urandom;
      acc  = !m_idle && !m_out && !m_hold && rdy;
      take = m_hold && irdy;
      if (acc) begin
         m_out   = 1'b1;
         m_addr  = m_pc;
         m_clean = !rv;
         m_wait  = (mem_delay == 0) ? int'($urandom_range(0, 3)) : mem_delay - 1;
      end else if (rsp_now) begin
         m_out = 1'b0;
         if (m_clean && !rv) begin
            m_hold = 1'b1;
            m_inst = mem_word(m_addr);
         end
      end else if (m_out) begin
         m_wait--;
      end
      if (rv) m_clean = 1'b0;
      if (m_hold && !rsp_now && (irdy || rv)) m_hold = 1'b0;
      if (take) m_cnt++;
      if (rv) m_pc = {rpc[63:2], 2'b00};
      else if (take) m_pc = m_pc + 64'd4;
      m_idle = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] c0;
      bus.imem_req_ready = 1'b0; bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
      use_hash = 1'b0; mem_delay = 1;
      #1 rst = 1'b1;
      #2 check_reset_outputs("rst");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Sequential fetch with always-ready memory and decoder.
      step(1, 1, 0, '0, 0);
      check("first_req_addr", bus.imem_req_addr, 64'h8000_0000);
      for (int unsigned i = 0; i < 9; i++) step(1, 1, 0, '0, 0);
      check("cnt3", bus.fetch_count, 64'd3);

      // Decoder backpressure in HOLD.
      step(1, 0, 0, '0, 0); step(1, 0, 0, '0, 0);
      for (int unsigned i = 0; i < 5; i++) step(1, 0, 0, '0, 0);
      step(1, 1, 0, '0, 0);
      check("bp_next_addr", bus.imem_req_addr, 64'h8000_0010);

      // Redirect in WAIT before the response, unaligned target.
      mem_delay = 3;
      step(1, 0, 0, '0, 0);
      step(0, 0, 1, 64'h8000_1002, 0);
      for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, '0, 0);
      check("redir_addr", bus.imem_req_addr, 64'h8000_1000);
      check("redir_req_valid", 64'(bus.imem_req_valid), 64'd1);
      mem_delay = 1;
      step(1, 0, 0, '0, 0); step(1, 0, 0, '0, 0);
      check("redir_inst_pc", bus.inst_pc, 64'h8000_1000);
      step(1, 1, 0, '0, 0);

      // Redirect with req_ready in REQ, then redirect with rsp_valid in WAIT.
      step(1, 0, 1, 64'h8000_2000, 0);
      step(0, 0, 0, '0, 0);
      check("drop_addr", bus.imem_req_addr, 64'h8000_2000);
      step(1, 0, 0, '0, 0);
      step(0, 0, 1, 64'h8000_3000, 0);
      check("rsp_redir_no_inst", 64'(bus.inst_valid), 64'd0);
      check("rsp_redir_addr", bus.imem_req_addr, 64'h8000_3000);

      // Redirect in HOLD with inst_ready.
      step(1, 0, 0, '0, 0); step(1, 0, 0, '0, 0);
      c0 = m_cnt;
      step(1, 1, 1, 64'h8000_4000, 0);
      check("hold_redir_cnt", bus.fetch_count, c0 + 64'd1);
      check("hold_redir_addr", bus.imem_req_addr, 64'h8000_4000);

      // PC wrap-around.
      step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
      step(1, 0, 0, '0, 0); step(1, 0, 0, '0, 0);
      check("wrap_inst_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1, 1, 0, '0, 0);
      check("wrap_addr", bus.imem_req_addr, 64'd0);

      // Reset asserted in WAIT; stale response after release is ignored.
      mem_delay = 3;
      step(1, 0, 0, '0, 0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(0, 0, 0, '0, 1);
      step(0, 0, 0, '0, 1);
      check("stale_no_inst", 64'(bus.inst_valid), 64'd0);
      for (int unsigned i = 0; i < 8; i++) step(1, 1, 0, '0, 0);

      // Randomized traffic.
      use_hash = 1'b1; mem_delay = 0;
      for (int unsigned i = 0; i < 4000; i++) begin
         logic [63:0] tgt;
         tgt = {32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 15) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFFE;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 7) == 0);
      end
      step(0, 0, 0, '0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/ysyx_22040125_ifu_fetch.md
Name: ysyx_22040125_ifu_fetch

Overview:
Instruction fetch stage directly upstream of the decoder. It owns the architectural PC and issues one instruction-memory read at a time over a valid/ready request channel. It buffers the returned 32-bit instruction and presents it with its PC to the decoder over a valid/ready channel. It accepts redirects (jump/branch targets) from later stages and discards stale in-flight fetches.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
ADDR_W, 64, PC / memory address width

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_W  fetch address (= pc)
imem_rsp_valid  in  1  response data valid (one per accepted request)
imem_rsp_data  in  32  fetched instruction word
inst_valid  out  1  instruction available to decoder
inst_ready  in  1  decoder consumes instruction this cycle
inst  out  32  instruction to decoder
inst_pc  out  ADDR_W  PC of inst
redirect_valid  in  1  PC redirect request
redirect_pc  in  ADDR_W  redirect target
fetch_count  out  64  number of instructions delivered (handshakes on inst channel)

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, inst=0, inst_pc=0, fetch_count=0. Outputs during reset: imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC.
- Redirect target alignment: redirect_pc[1:0] forced to 2'b00 on load. pc+4 wraps modulo 2^ADDR_W.
- imem_req_valid=1 only in REQ. inst_valid=1 only in HOLD. imem_req_addr=pc always.
- At most one outstanding memory request. imem_rsp_valid outside WAIT/DROP is ignored.
- States and transitions, evaluated in priority order:
  - IDLE: next cycle -> REQ. Redirect in IDLE: pc<=redirect_pc, -> REQ.
  - REQ:
    - req_ready & redirect: request issued with old pc; pc<=redirect_pc; -> DROP.
    - redirect only: pc<=redirect_pc; stay REQ (new address next cycle).
    - req_ready only: -> WAIT.
  - WAIT:
    - rsp_valid & redirect: data discarded; pc<=redirect_pc; -> REQ.
    - redirect only: pc<=redirect_pc; -> DROP.
    - rsp_valid only: inst<=imem_rsp_data, inst_pc<=pc; -> HOLD.
  - DROP:
    - rsp_valid: discard data; -> REQ. If redirect in the same cycle, pc<=redirect_pc as well.
    - redirect only: pc<=redirect_pc; stay DROP.
  - HOLD:
    - inst, inst_pc held stable while inst_valid=1 and not consumed.
    - inst_ready & ~redirect: pc<=pc+4, fetch_count+=1; -> REQ.
    - redirect, with or without inst_ready: pc<=redirect_pc; -> REQ. fetch_count+=1 only if inst_ready was high.
- Redirect always wins over sequential pc+4.
- Best-case throughput with memory ready and a 1-cycle response: 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Latency: from req accept to inst_valid = response latency + 1 cycle.
- fetch_count wraps modulo 2^64.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight response arriving after release is ignored because state is IDLE.

Test Plan:
- Reset release, always-ready memory returning 0x00000013 one cycle after accept, inst_ready=1 -> first req addr 0x80000000. inst_valid with inst_pc=0x80000000, then 0x80000004, 0x80000008. fetch_count=3 after three handshakes.
- Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, imem_req_valid=0. On inst_ready=1 the next req addr is pc+4.
- Redirect in WAIT to 0x80001002 before response -> response discarded (no inst_valid). Next req addr 0x80001000. Next inst_pc=0x80001000.
- Redirect coincident with req_ready in REQ -> state DROP. First response dropped, then req to redirect target. Redirect coincident with rsp_valid in WAIT -> no inst_valid, next req to target.
- Redirect in HOLD with inst_ready=1 -> fetch_count increments, next req addr = redirect_pc, not pc+4.
- pc=0xFFFFFFFFFFFFFFFC delivered and consumed -> next req addr 0x0. Assert rst while in WAIT -> outputs return to reset values immediately, and a stale rsp_valid after release produces no inst_valid.
